// File: rtl/cp0_exception_ctrl.sv
// CP0 exception controller: SR/Cause/EPC/PRId registers, interrupt request
// generation and exception/eret sequencing for a MIPS-style pipeline.
module cp0_exception_ctrl #(
  parameter int unsigned HW_INT_COUNT = 6,
  parameter logic [31:0] SR_RESET     = 32'h0000_FC01,
  parameter logic [31:0] PRID_VALUE   = 32'h9340_A215
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4:0]              read_address,
  output logic [31:0]             read_data,
  input  logic                    write_enable,
  input  logic [4:0]              write_address,
  input  logic [31:0]             write_data,
  input  logic [HW_INT_COUNT-1:0] hw_int,
  input  logic                    exc_valid,
  input  logic [4:0]              exc_code,
  input  logic [31:0]             exc_pc,
  input  logic                    exc_bd,
  input  logic                    eret,
  output logic                    int_req,
  output logic                    exc_taken,
  output logic [31:0]             sr_out,
  output logic [31:0]             cause_out,
  output logic [31:0]             epc_out
);

  localparam int unsigned IM_LO = 10;
  localparam int unsigned IM_HI = 9 + HW_INT_COUNT;

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  logic [HW_INT_COUNT-1:0] im_q, im_d;
  logic [HW_INT_COUNT-1:0] ip_q, ip_d;
  logic                    exl_q, exl_d;
  logic                    ie_q, ie_d;
  logic                    bd_q, bd_d;
  logic [4:0]              exc_code_q, exc_code_d;
  logic [31:0]             epc_q, epc_d;

  logic [31:0] sr_s;
  logic [31:0] cause_s;
  logic        int_req_s;
  logic        exc_taken_s;

  // Assemble architectural SR/Cause views; unimplemented bits read as zero.
  always_comb begin
    sr_s                = 32'h0000_0000;
    sr_s[IM_HI:IM_LO]   = im_q;
    sr_s[1]             = exl_q;
    sr_s[0]             = ie_q;
    cause_s             = 32'h0000_0000;
    cause_s[31]         = bd_q;
    cause_s[IM_HI:IM_LO] = ip_q;
    cause_s[6:2]        = exc_code_q;
  end

  // Interrupt request and exception acceptance; both forced low while in reset.
  always_comb begin
    int_req_s   = reset & (|(ip_q & im_q)) & ie_q & ~exl_q;
    exc_taken_s = reset & (int_req_s | (exc_valid & ~exl_q));
  end

  // Next-state: mtc0 lowest priority, then eret, then exception entry.
  always_comb begin
    im_d       = im_q;
    ie_d       = ie_q;
    exl_d      = exl_q;
    bd_d       = bd_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    ip_d       = hw_int;

    if (write_enable) begin
      case (write_address)
        ADDR_SR: begin
          im_d  = write_data[IM_HI:IM_LO];
          exl_d = write_data[1];
          ie_d  = write_data[0];
        end
        ADDR_EPC: epc_d = write_data & 32'hFFFF_FFFC;
        default:  epc_d = epc_q;
      endcase
    end else begin
      epc_d = epc_q;
    end

    exl_d = eret ? 1'b0 : exl_d;

    if (exc_taken_s) begin
      exl_d      = 1'b1;
      bd_d       = exc_bd;
      epc_d      = (exc_pc & 32'hFFFF_FFFC) - (exc_bd ? 32'd4 : 32'd0);
      exc_code_d = int_req_s ? 5'd0 : exc_code;
    end else begin
      bd_d = bd_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im_q       <= SR_RESET[IM_HI:IM_LO];
      exl_q      <= SR_RESET[1];
      ie_q       <= SR_RESET[0];
      ip_q       <= '0;
      bd_q       <= 1'b0;
      exc_code_q <= 5'd0;
      epc_q      <= 32'h0000_0000;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      ip_q       <= ip_d;
      bd_q       <= bd_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

  // mfc0 read mux, combinational from current state (no write bypass).
  always_comb begin
    case (read_address)
      ADDR_SR:    read_data = sr_s;
      ADDR_CAUSE: read_data = cause_s;
      ADDR_EPC:   read_data = epc_q;
      ADDR_PRID:  read_data = PRID_VALUE;
      default:    read_data = 32'h0000_0000;
    endcase
  end

  assign int_req   = int_req_s;
  assign exc_taken = exc_taken_s;
  assign sr_out    = sr_s;
  assign cause_out = cause_s;
  assign epc_out   = epc_q;

endmodule

// File: tb/tb_cp0_exception_ctrl.sv
// Self-checking bench for cp0_exception_ctrl: directed scenarios with literal
// expectations, then randomized traffic checked against a word-level model.
module tb_cp0_exception_ctrl;

  localparam int unsigned N          = 6;
  localparam logic [31:0] SR_RST     = 32'h0000_FC01;
  localparam logic [31:0] PRID       = 32'h9340_A215;
  localparam logic [31:0] IM_MASK    = ((32'd1 << N) - 32'd1) << 10;
  localparam logic [31:0] SR_MASK    = IM_MASK | 32'd3;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    read_address;
  logic [31:0]   read_data;
  logic          write_enable;
  logic [4:0]    write_address;
  logic [31:0]   write_data;
  logic [N-1:0]  hw_int;
  logic          exc_valid;
  logic [4:0]    exc_code;
  logic [31:0]   exc_pc;
  logic          exc_bd;
  logic          eret;
  logic          int_req;
  logic          exc_taken;
  logic [31:0]   sr_out;
  logic [31:0]   cause_out;
  logic [31:0]   epc_out;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_sr, m_cause, m_epc;

  cp0_exception_ctrl #(.HW_INT_COUNT(N), .SR_RESET(SR_RST), .PRID_VALUE(PRID)) dut (
    .clk(clk), .reset(reset), .read_address(read_address), .read_data(read_data),
    .write_enable(write_enable), .write_address(write_address), .write_data(write_data),
    .hw_int(hw_int), .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
    .exc_bd(exc_bd), .eret(eret), .int_req(int_req), .exc_taken(exc_taken),
    .sr_out(sr_out), .cause_out(cause_out), .epc_out(epc_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_sr    = SR_RST & SR_MASK;
    m_cause = 32'd0;
    m_epc   = 32'd0;
  endtask

  function automatic bit m_int();
    return ((m_cause & m_sr & IM_MASK) != 32'd0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic bit m_taken();
    return reset && (m_int() || (exc_valid && !m_sr[1]));
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'd0;
    endcase
  endfunction

  task automatic compare_all();
    chk("read_data", read_data, m_read(read_address));
    chk("sr_out", sr_out, m_sr);
    chk("cause_out", cause_out, m_cause);
    chk("epc_out", epc_out, m_epc);
    chk("int_req", {31'd0, int_req}, {31'd0, reset && m_int()});
    chk("exc_taken", {31'd0, exc_taken}, {31'd0, m_taken()});
  endtask

  task automatic model_edge();
    logic [31:0] sr_n, cause_n, epc_n, ip;
    bit ir, tk;
    if (!reset) begin
      model_reset();
    end else begin
      ir      = m_int();
      tk      = m_taken();
      ip      = 32'(hw_int) << 10;
      sr_n    = m_sr;
      epc_n   = m_epc;
      cause_n = (m_cause & ~IM_MASK) | ip;
      if (write_enable && write_address == 5'd12) sr_n = write_data & SR_MASK;
      if (write_enable && write_address == 5'd14) epc_n = write_data & ~32'd3;
      if (eret) sr_n = sr_n & ~32'd2;
      if (tk) begin
        sr_n    = sr_n | 32'd2;
        cause_n = (32'(exc_bd) << 31) | ip | ((ir ? 32'd0 : 32'(exc_code)) << 2);
        epc_n   = (exc_pc & ~32'd3) - (exc_bd ? 32'd4 : 32'd0);
      end
      m_sr    = sr_n;
      m_cause = cause_n;
      m_epc   = epc_n;
    end
  endtask

  // Compare at the current (off-edge) time, then advance across one posedge.
  task automatic tick();
    compare_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    write_enable = 1'b0; write_address = 5'd0; write_data = 32'd0;
    exc_valid = 1'b0; exc_code = 5'd0; exc_pc = 32'd0; exc_bd = 1'b0; eret = 1'b0;
  endtask

  initial begin
    reset = 1'b0; read_address = 5'd12; hw_int = '0;
    idle();
    model_reset();
    @(negedge clk);
    exc_valid = 1'b1;
    #1; chk("exc_taken_in_reset", {31'd0, exc_taken}, 32'd0);
    tick();
    exc_valid = 1'b0;
    reset = 1'b1;

    // Reset values through the read port.
    read_address = 5'd12; #1; chk("rd_sr_rst", read_data, 32'h0000_FC01); tick();
    read_address = 5'd13; #1; chk("rd_cause_rst", read_data, 32'd0); tick();
    read_address = 5'd14; #1; chk("rd_epc_rst", read_data, 32'd0); tick();
    read_address = 5'd15; #1; chk("rd_prid", read_data, 32'h9340_A215); tick();
    read_address = 5'd7;  #1; chk("rd_unmapped", read_data, 32'd0); tick();
    read_address = 5'd13;

    // Interrupt on line 2.
    hw_int = 6'b000100; #1; tick();
    hw_int = '0; exc_pc = 32'h0000_2000;
    #1;
    chk("irq_cause", cause_out, 32'h0000_1000);
    chk("irq_int_req", {31'd0, int_req}, 32'd1);
    chk("irq_taken", {31'd0, exc_taken}, 32'd1);
    tick();
    #1;
    chk("irq_sr", sr_out, 32'h0000_FC03);
    chk("irq_cause_after", cause_out, 32'd0);
    chk("irq_epc", epc_out, 32'h0000_2000);
    chk("irq_int_req_after", {31'd0, int_req}, 32'd0);
    idle(); eret = 1'b1; tick();

    // Delay-slot exception, then one ignored while EXL=1.
    idle(); exc_valid = 1'b1; exc_code = 5'd4; exc_pc = 32'h0000_3010; exc_bd = 1'b1;
    #1; chk("ds_taken", {31'd0, exc_taken}, 32'd1); tick();
    exc_code = 5'd7; exc_pc = 32'h0000_5000; exc_bd = 1'b0;
    #1;
    chk("ds_epc", epc_out, 32'h0000_300C);
    chk("ds_cause", cause_out, 32'h8000_0010);
    chk("ds_sr", sr_out, 32'h0000_FC03);
    chk("ds_ignored_taken", {31'd0, exc_taken}, 32'd0);
    tick();
    idle();
    #1;
    chk("ds_epc_hold", epc_out, 32'h0000_300C);
    chk("ds_cause_hold", cause_out, 32'h8000_0010);
    tick();

    // Interrupt beats a same-cycle exception; eret loses to exc_taken.
    eret = 1'b1; hw_int = 6'b000001; #1; tick();
    idle(); exc_valid = 1'b1; exc_code = 5'd12; exc_pc = 32'h0000_6000;
    #1; chk("pri_int_req", {31'd0, int_req}, 32'd1); tick();
    idle();
    #1;
    chk("pri_cause", cause_out, 32'h0000_0400);
    chk("pri_sr", sr_out, 32'h0000_FC03);
    eret = 1'b1; tick();
    hw_int = '0;
    #1; chk("eret_vs_taken", {31'd0, exc_taken}, 32'd1); tick();
    #1; chk("eret_exl_stays", sr_out, 32'h0000_FC03);

    // mtc0 behaviour.
    write_enable = 1'b1; write_address = 5'd12; write_data = 32'hFFFF_FFFF; tick();
    eret = 1'b0; write_address = 5'd14; write_data = 32'h0000_3007;
    #1; chk("mtc0_sr_eret", sr_out, 32'h0000_FC01); tick();
    write_address = 5'd13; write_data = 32'hFFFF_FFFF;
    #1; chk("mtc0_epc", epc_out, 32'h0000_3004); tick();
    idle();
    #1; chk("mtc0_cause_ignored", cause_out, 32'd0); tick();

    // Asynchronous reset mid-cycle with EXL=1 and EPC nonzero.
    exc_valid = 1'b1; exc_code = 5'd8; exc_pc = 32'h0000_4000; #1; tick();
    idle();
    #1;
    chk("pre_rst_sr", sr_out, 32'h0000_FC03);
    chk("pre_rst_epc", epc_out, 32'h0000_4000);
    #2; reset = 1'b0; model_reset();
    #1;
    chk("arst_sr", sr_out, 32'h0000_FC01);
    chk("arst_cause", cause_out, 32'd0);
    chk("arst_epc", epc_out, 32'd0);
    chk("arst_int_req", {31'd0, int_req}, 32'd0);
    write_enable = 1'b1; write_address = 5'd14; write_data = 32'h0000_1234; exc_valid = 1'b1;
    chk("arst_taken", {31'd0, exc_taken}, 32'd0);
    tick();
    reset = 1'b1; idle();
    #1;
    chk("rst_wins_epc", epc_out, 32'd0);
    chk("rst_wins_sr", sr_out, 32'h0000_FC01);
    tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset         = (!reset) ? 1'b1 : ($urandom_range(0, 149) != 0);
      hw_int        = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      exc_valid     = ($urandom_range(0, 3) == 0);
      exc_code      = 5'($urandom);
      exc_pc        = $urandom;
      exc_bd        = $urandom_range(0, 1) == 1;
      eret          = ($urandom_range(0, 5) == 0);
      write_enable  = ($urandom_range(0, 2) == 0);
      write_address = ($urandom_range(0, 3) != 0) ? 5'(12 + $urandom_range(0, 3)) : 5'($urandom);
      write_data    = $urandom;
      read_address  = ($urandom_range(0, 3) != 0) ? 5'(12 + $urandom_range(0, 3)) : 5'($urandom);
      if (!reset) model_reset();
      #1;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
